mac_accum_serializer: RTL and testbench
=======================================

# mac_accum_serializer

Downstream consumer of the 8x8 signed Booth multiplier. It accepts the multiplier's 16-bit signed products and sign-extends them into a wider running accumulator. On command, it snapshots the accumulator and streams it out one byte per transfer over a valid/ready handshake, so the result fits the 8-bit output pins of the tile. It turns the combinational multiplier into a multiply-accumulate datapath with a byte-wide readout.

## Interface
- ACC_W, 24, accumulator width in bits; multiple of 8, ≥ 16; NBYTES = ACC_W/8
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- prod  in  16  signed product from multiplier
- prod_valid  in  1  prod is valid this cycle
- prod_ready  out  1  block can accept prod this cycle
- clr  in  1  clear accumulator and overflow flag
- dump  in  1  request to snapshot and stream the accumulator
- out_byte  out  8  current output byte, least significant byte first
- out_valid  out  1  out_byte is valid
- out_ready  in  1  consumer accepts out_byte
- out_last  out  1  out_byte is the final byte of the stream
- ovf  out  1  sticky signed-overflow flag
- busy  out  1  stream in progress

## Operation
- Reset values:
  - acc = 0, shift register = 0, byte count = 0
  - out_byte = 0x00, out_valid = 0, out_last = 0, ovf = 0, busy = 0
  - prod_ready = 1, state = IDLE
- The state machine has two states, IDLE and STREAM.
- IDLE:
  - prod_ready = 1.
  - A product is accepted on prod_valid & prod_ready; acc ← acc + sext(prod) to ACC_W.
  - Signed overflow is detected when both operands share a sign and the sum's sign differs. On overflow, ovf is set and stays set until clr or reset.
- clr in IDLE: acc ← 0, ovf ← 0. clr together with an accepted product: acc ← sext(prod), ovf ← 0.
- dump in IDLE:
  - The shift register loads the value acc would take this cycle, so an accepted product and clr in the same cycle are both included.
  - The byte count loads NBYTES−1.
  - The state goes to STREAM.
  - acc is kept unless clr is also asserted.
- STREAM:
  - prod_ready = 0, and prod_valid is ignored (no accumulate).
  - out_valid = 1, busy = 1, out_byte = shift[7:0].
  - On out_valid & out_ready: shift ← shift >> 8, count decrements.
  - out_last = 1 when count = 0.
  - A transfer with out_last returns the state to IDLE.
- dump during STREAM is ignored.
- clr during STREAM clears acc and ovf but does not abort or alter the stream.
- When out_ready is low, out_byte and out_last hold stable.

## Timing
- Accumulate: the updated acc and ovf are visible the cycle after acceptance. Back-to-back accepts are allowed every cycle.
- Dump latency: out_valid rises in the cycle after dump is sampled in IDLE.
- Stream length: NBYTES transfers. The minimum is NBYTES cycles with out_ready held high.
- Return to IDLE: prod_ready = 1 in the cycle after the out_last transfer. dump may be re-asserted that same cycle.
- rst_n low at any time, including mid-stream: all outputs take their reset values the following cycle. The partial stream is discarded.

## Configuration
- Macro: ACC_SAT_EN.
- Defined: on overflow, acc saturates to the signed maximum (0x7F..F) or minimum (0x80..0) of ACC_W, and ovf is set.
- Undefined: acc wraps modulo 2^ACC_W, and ovf is still set.

## Test plan
- ACC_W=24, three accepted products of 0x0064, then dump with out_ready=1:
  - bytes 0x2C, 0x01, 0x00 on three consecutive cycles
  - out_last only on 0x00
  - ovf=0
- After clr, one product 0xFF80 (−128), then dump: bytes 0x80, 0xFF, 0xFF.
- Backpressure: out_ready low for 3 cycles after byte0 of the 300 stream:
  - out_byte holds 0x01 with out_valid=1 for those 3 cycles
  - no byte is lost or duplicated
  - prod_valid pulses during the stream leave acc unchanged
- Simultaneous events: with acc=5, assert prod=0x0003, prod_valid and dump in the same cycle; the stream reports 0x08, 0x00, 0x00.
- ACC_W=16, products 0x7FFF then 0x0001:
  - with ACC_SAT_EN: acc=0x7FFF, ovf=1
  - without ACC_SAT_EN: acc=0x8000, ovf=1
  - clr then returns ovf to 0
- rst_n low during byte1 of a stream: the next cycle has out_valid=0, busy=0, prod_ready=1, out_byte=0x00; a following dump streams 0x00, 0x00, 0x00.

Source files
------------

// File: rtl/mac_accum_serializer_if.sv
// Product input stream and byte-wide readout stream of the MAC serializer.
// The block sits on the slave modport; the producer/consumer side uses master.
interface mac_accum_serializer_if;
    logic [15:0] prod;
    logic        prod_valid;
    logic        prod_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output prod, prod_valid, out_ready,
        input  prod_ready, out_byte, out_valid, out_last
    );

    modport slave (
        input  prod, prod_valid, out_ready,
        output prod_ready, out_byte, out_valid, out_last
    );
endinterface

// File: rtl/mac_accum_serializer.sv
// Multiply-accumulate back end: sign-extends 16-bit products into an ACC_W accumulator
// and streams a snapshot out LSB first. Optional macro ACC_SAT_EN saturates on overflow.
//
// state  | meaning
// IDLE   | accepting products, waiting for dump
// STREAM | presenting snapshot bytes on the output handshake
module mac_accum_serializer #(
    parameter int ACC_W = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mac_accum_serializer_if.slave       bus,
    input  logic                        clr,
    input  logic                        dump,
    output logic                        ovf,
    output logic                        busy
);
    localparam int NBYTES = ACC_W / 8;
    localparam int CNT_W  = (NBYTES > 2) ? $clog2(NBYTES) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   shift;
    logic [CNT_W-1:0]   cnt;

    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W-1:0]   prod_sext;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   acc_next;
    logic               accept;
    logic               sum_ovf;
    logic               ovf_next;

    always_comb begin
        accept    = (state == IDLE) && bus.prod_valid;
        prod_sext = ACC_W'($signed(bus.prod));
        acc_base  = clr ? '0 : acc;
        sum       = acc_base + prod_sext;
        sum_ovf   = (acc_base[ACC_W-1] == prod_sext[ACC_W-1]) &&
                    (sum[ACC_W-1] != acc_base[ACC_W-1]);
        acc_next  = acc_base;
        ovf_next  = clr ? 1'b0 : ovf;
        if (accept) begin
            acc_next = sum;
            if (sum_ovf) begin
                ovf_next = 1'b1;
`ifdef ACC_SAT_EN
                // Both operands share a sign, so the base sign picks the rail.
                acc_next = acc_base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                             : {1'b0, {(ACC_W-1){1'b1}}};
`else
                acc_next = sum;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            acc            <= '0;
            ovf            <= 1'b0;
            shift          <= '0;
            cnt            <= '0;
            busy           <= 1'b0;
            bus.prod_ready <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.out_last   <= 1'b0;
        end else begin
            acc <= acc_next;
            ovf <= ovf_next;
            if (state == IDLE) begin
                if (dump) begin
                    // Snapshot includes any product and clr taken this same cycle.
                    shift          <= acc_next;
                    cnt            <= CNT_W'(NBYTES - 1);
                    state          <= STREAM;
                    busy           <= 1'b1;
                    bus.prod_ready <= 1'b0;
                    bus.out_valid  <= 1'b1;
                    bus.out_last   <= 1'b0;
                end
            end else begin
                if (bus.out_ready) begin
                    shift <= shift >> 8;
                    if (bus.out_last) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        bus.prod_ready <= 1'b1;
                        bus.out_valid  <= 1'b0;
                        bus.out_last   <= 1'b0;
                    end else begin
                        cnt          <= cnt - 1'b1;
                        bus.out_last <= (cnt == CNT_W'(1));
                    end
                end
            end
        end
    end

    assign bus.out_byte = shift[7:0];
endmodule

// File: tb/tb_mac_accum_serializer.sv
// Randomized scoreboard bench for mac_accum_serializer (24-bit main instance plus a
// 16-bit instance for the overflow corner).
module tb_mac_accum_serializer;
    logic clk = 1'b0;
    logic rst_n;
    logic clr, dump, ovf, busy;
    logic clr16, dump16, ovf16, busy16;

    mac_accum_serializer_if bus ();
    mac_accum_serializer_if bus16 ();

    mac_accum_serializer #(.ACC_W(24)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .clr(clr), .dump(dump), .ovf(ovf), .busy(busy)
    );

    mac_accum_serializer #(.ACC_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16.slave),
        .clr(clr16), .dump(dump16), .ovf(ovf16), .busy(busy16)
    );

    always #5 clk = ~clk;

    localparam int MAXV = (1 << 23) - 1;
    localparam int MINV = -(1 << 23);

    int n_checks = 0;
    int n_fail   = 0;
    int acc_m    = 0;
    bit ovf_m    = 1'b0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference accumulator: plain integer sum, range-checked against the 24-bit signed span.
    task automatic add_prod(input logic [15:0] p);
        int s;
        s = acc_m + int'($signed(p));
        if (s > MAXV || s < MINV) begin
            ovf_m = 1'b1;
`ifdef ACC_SAT_EN
            acc_m = (s > MAXV) ? MAXV : MINV;
`else
            acc_m = (s > MAXV) ? s - (1 << 24) : s + (1 << 24);
`endif
        end else begin
            acc_m = s;
        end
    endtask

    task automatic push_bytes();
        logic [23:0] v;
        v = acc_m[23:0];
        for (int i = 0; i < 3; i++)
            exp_q.push_back({(i == 2), v[8*i +: 8]});
    endtask

    task automatic step(input bit pv, input logic [15:0] p, input bit c, input bit d);
        bus.prod_valid = pv;
        bus.prod       = p;
        clr            = c;
        dump           = d;
        tick();
        bus.prod_valid = 1'b0;
        clr            = 1'b0;
        dump           = 1'b0;
        if (c) begin
            acc_m = 0;
            ovf_m = 1'b0;
        end
        if (pv) add_prod(p);
        check("ovf", ovf, ovf_m);
        if (d) begin
            push_bytes();
            check("dump_out_valid", bus.out_valid, 1);
            check("dump_busy", busy, 1);
            check("dump_prod_ready", bus.prod_ready, 0);
        end
    endtask

    // Runs the stream to completion with random stalls, ignored products and clr pulses.
    task automatic drain(input int stall_pct);
        int budget;
        bit c;
        budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            bus.out_ready  = ($urandom_range(99) >= stall_pct);
            bus.prod_valid = ($urandom_range(3) == 0);
            bus.prod       = 16'($urandom);
            c              = ($urandom_range(7) == 0);
            clr            = c;
            tick();
            if (c) begin
                acc_m = 0;
                ovf_m = 1'b0;
            end
            budget--;
        end
        bus.out_ready  = 1'b1;
        bus.prod_valid = 1'b0;
        clr            = 1'b0;
        check("drain_done", exp_q.size(), 0);
        check("return_prod_ready", bus.prod_ready, 1);
        check("return_busy", busy, 0);
        check("return_ovf", ovf, ovf_m);
    endtask

    // Monitor: compares every accepted byte against the scoreboard.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {bus.out_last, bus.out_byte}, 9'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_byte", {23'd0, bus.out_last, bus.out_byte}, {23'd0, e});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] lo16, hi16;
        rst_n = 1'b0;
        clr = 1'b0; dump = 1'b0;
        clr16 = 1'b0; dump16 = 1'b0;
        bus.prod = '0; bus.prod_valid = 1'b0; bus.out_ready = 1'b1;
        bus16.prod = '0; bus16.prod_valid = 1'b0; bus16.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_byte", bus.out_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_prod_ready", bus.prod_ready, 1);
        rst_n = 1'b1;
        tick();

        // 16-bit accumulator overflow corner
`ifdef ACC_SAT_EN
        lo16 = 8'hFF; hi16 = 8'h7F;
`else
        lo16 = 8'h00; hi16 = 8'h80;
`endif
        bus16.prod_valid = 1'b1; bus16.prod = 16'h7FFF; tick();
        check("acc16_ovf_first", ovf16, 0);
        bus16.prod = 16'h0001; tick();
        bus16.prod_valid = 1'b0;
        check("acc16_ovf_set", ovf16, 1);
        dump16 = 1'b1; tick(); dump16 = 1'b0;
        check("acc16_byte0", {bus16.out_valid, bus16.out_last, bus16.out_byte}, {2'b10, lo16});
        tick();
        check("acc16_byte1", {bus16.out_valid, bus16.out_last, bus16.out_byte}, {2'b11, hi16});
        tick();
        check("acc16_idle", {busy16, bus16.prod_ready}, 2'b01);
        clr16 = 1'b1; tick(); clr16 = 1'b0;
        check("acc16_ovf_clr", ovf16, 0);

        // 3 x 100 = 300 streams 2C 01 00
        repeat (3) step(1'b1, 16'h0064, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        drain(0);

        // -128 after clr streams 80 FF FF
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'hFF80, 1'b0, 1'b1);
        drain(0);

        // Backpressure on the 300 stream with ignored products while stalled
        step(1'b1, 16'h0064, 1'b1, 1'b0);
        repeat (2) step(1'b1, 16'h0064, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_byte", {bus.out_valid, bus.out_byte}, 9'h101);
            bus.prod_valid = 1'b1;
            bus.prod = 16'($urandom);
            tick();
        end
        bus.prod_valid = 1'b0;
        drain(0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        drain(0);

        // acc=5 then product 3 with dump in the same cycle streams 08 00 00
        step(1'b1, 16'h0005, 1'b1, 1'b0);
        step(1'b1, 16'h0003, 1'b0, 1'b1);
        drain(0);

        // Reset during byte1 discards the stream
        step(1'b1, 16'h1234, 1'b1, 1'b1);
        tick();
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        acc_m = 0;
        ovf_m = 1'b0;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_prod_ready", bus.prod_ready, 1);
        check("midrst_out_byte", bus.out_byte, 0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        drain(0);

        // Randomized accumulate/dump traffic with stalls and in-stream clr
        for (int it = 0; it < 30; it++) begin
            int n;
            n = $urandom_range(4);
            for (int k = 0; k < n; k++)
                step(($urandom_range(4) != 0), 16'($urandom), ($urandom_range(9) == 0), 1'b0);
            step($urandom_range(1), 16'($urandom), ($urandom_range(7) == 0), 1'b1);
            drain(30);
        end

        // Drive the 24-bit accumulator past its positive limit
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int k = 0; k < 260; k++)
            step(1'b1, 16'h7FFF, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        drain(0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("ovf_after_clr", ovf, 0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
